// File: rtl/udp_header_rx_mp.sv
// Multi-port UDP header receiver: parses the 8-byte header, matches the destination port, forwards the payload.
// Optional checksum verification is built when UDP_RX_CSUM_EN is defined.
module udp_header_rx_mp #(
  parameter int NUM_PORTS   = 4,
  parameter int MAX_PAYLOAD = 1472,
  parameter int IDX_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [7:0]               data_in,
  input  logic                     data_valid,
  input  logic                     ip_header_done,
  input  logic [16*NUM_PORTS-1:0]  port_table,
  input  logic [NUM_PORTS-1:0]     port_en,
`ifdef UDP_RX_CSUM_EN
  input  logic [15:0]              pseudo_sum,
  output logic                     csum_ok,
`endif
  output logic [15:0]              port_s,
  output logic [15:0]              udp_length,
  output logic [IDX_W-1:0]         port_idx,
  output logic [7:0]               udp_data,
  output logic                     udp_data_valid,
  output logic                     udp_data_tlast,
  output logic                     drop,
  output logic                     len_err
);

  typedef enum logic [3:0] {
    IDLE, SRC_LO, DST_HI, DST_LO, LEN_HI, LEN_LO, CSUM_HI, CSUM_LO, PAYLOAD, DISCARD
  } state_t;

  state_t           r_state, w_next;
  logic [7:0]       r_byte_hi;
  logic [15:0]      r_remain;
  logic [15:0]      w_len;
  logic             w_len_bad;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic             w_drop, w_len_err, w_beat, w_last;

  assign w_len     = {r_byte_hi, data_in};
  assign w_len_bad = (w_len < 16'd8) || ({1'b0, w_len} > 17'(MAX_PAYLOAD + 8));

  // Scan downwards so the lowest enabled matching entry is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_en[i] && (port_table[16*i +: 16] == {r_byte_hi, data_in})) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_drop    = 1'b0;
    w_len_err = 1'b0;
    w_beat    = 1'b0;
    w_last    = 1'b0;
    if (r_state != IDLE && !data_valid) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (ip_header_done && data_valid) w_next = SRC_LO;
        SRC_LO:  w_next = DST_HI;
        DST_HI:  w_next = DST_LO;
        DST_LO: begin
          if (w_hit) begin
            w_next = LEN_HI;
          end else begin
            w_drop = 1'b1;
            w_next = DISCARD;
          end
        end
        LEN_HI:  w_next = LEN_LO;
        LEN_LO: begin
          if (w_len_bad) begin
            w_len_err = 1'b1;
            w_next    = DISCARD;
          end else begin
            w_next = CSUM_HI;
          end
        end
        CSUM_HI: w_next = CSUM_LO;
        CSUM_LO: w_next = (udp_length == 16'd8) ? IDLE : PAYLOAD;
        PAYLOAD: begin
          w_beat = 1'b1;
          w_last = (r_remain == 16'd1);
          if (w_last) w_next = DISCARD;
        end
        DISCARD: w_next = DISCARD;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      port_s         <= '0;
      udp_length     <= '0;
      port_idx       <= '0;
      udp_data       <= '0;
      udp_data_valid <= 1'b0;
      udp_data_tlast <= 1'b0;
      drop           <= 1'b0;
      len_err        <= 1'b0;
      r_byte_hi      <= '0;
      r_remain       <= '0;
    end else begin
      udp_data_valid <= w_beat;
      udp_data_tlast <= w_last;
      drop           <= w_drop;
      len_err        <= w_len_err;
      if (data_valid) begin
        case (r_state)
          IDLE:    if (ip_header_done) port_s[15:8] <= data_in;
          SRC_LO:  port_s[7:0] <= data_in;
          DST_HI, LEN_HI, CSUM_HI: r_byte_hi <= data_in;
          DST_LO:  if (w_hit) port_idx <= w_idx;
          LEN_LO:  udp_length <= w_len;
          CSUM_LO: r_remain <= udp_length - 16'd8;
          PAYLOAD: begin
            udp_data <= data_in;
            r_remain <= r_remain - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UDP_RX_CSUM_EN
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  logic [15:0] r_acc, w_cs_word, w_cs_sum, w_cs_fin;
  logic [7:0]  r_pay_hi;
  logic        r_odd, r_csum_zero, w_cs_add;

  // An odd trailing payload byte is summed as the high half of a zero-padded word.
  always_comb begin
    w_cs_word = {r_byte_hi, data_in};
    w_cs_add  = 1'b0;
    case (r_state)
      SRC_LO: begin
        w_cs_word = {port_s[15:8], data_in};
        w_cs_add  = 1'b1;
      end
      DST_LO, LEN_LO, CSUM_LO: w_cs_add = 1'b1;
      PAYLOAD: begin
        if (r_odd) begin
          w_cs_word = {r_pay_hi, data_in};
          w_cs_add  = 1'b1;
        end else if (w_last) begin
          w_cs_word = {data_in, 8'h00};
          w_cs_add  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_cs_sum = oc_add(r_acc, w_cs_word);
  assign w_cs_fin = oc_add(w_cs_sum, pseudo_sum);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_acc       <= '0;
      r_pay_hi    <= '0;
      r_odd       <= 1'b0;
      r_csum_zero <= 1'b0;
      csum_ok     <= 1'b0;
    end else begin
      csum_ok <= w_last && ((w_cs_fin == 16'hFFFF) || r_csum_zero);
      if (data_valid) begin
        if (r_state == IDLE && ip_header_done) begin
          r_acc <= '0;
          r_odd <= 1'b0;
        end else if (w_cs_add) begin
          r_acc <= w_cs_sum;
        end
        if (r_state == CSUM_LO) r_csum_zero <= (w_cs_word == 16'h0000);
        if (r_state == PAYLOAD) begin
          if (!r_odd) r_pay_hi <= data_in;
          r_odd <= ~r_odd;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_udp_header_rx_mp.sv
// Directed bench for udp_header_rx_mp: vector table plus hand-written corner sequences.
// Checksum cases run only when UDP_RX_CSUM_EN is defined.
module tb_udp_header_rx_mp;
  localparam int NP = 4;
  localparam int IW = 2;
  localparam logic [63:0] T1 = {16'd8000, 16'd7000, 16'd6000, 16'd5000};
  localparam logic [63:0] T2 = {16'd8000, 16'd7000, 16'd5000, 16'd7000};

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [7:0]    data_in = '0;
  logic          data_valid = 1'b0;
  logic          ip_header_done = 1'b0;
  logic [63:0]   port_table = T1;
  logic [NP-1:0] port_en = 4'hF;
  logic [15:0]   port_s, udp_length;
  logic [IW-1:0] port_idx;
  logic [7:0]    udp_data;
  logic          udp_data_valid, udp_data_tlast, drop, len_err;
`ifdef UDP_RX_CSUM_EN
  logic [15:0]   pseudo_sum = 16'h1234;
  logic          csum_ok;
  logic          mon_csum = 1'b0;
`endif

  udp_header_rx_mp #(.NUM_PORTS(NP), .MAX_PAYLOAD(1472)) dut (
    .aclk(aclk), .aresetn(aresetn), .data_in(data_in), .data_valid(data_valid),
    .ip_header_done(ip_header_done), .port_table(port_table), .port_en(port_en),
`ifdef UDP_RX_CSUM_EN
    .pseudo_sum(pseudo_sum), .csum_ok(csum_ok),
`endif
    .port_s(port_s), .udp_length(udp_length), .port_idx(port_idx), .udp_data(udp_data),
    .udp_data_valid(udp_data_valid), .udp_data_tlast(udp_data_tlast),
    .drop(drop), .len_err(len_err)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] mon_q[$];
  int n_drop = 0, n_lerr = 0, n_orphan = 0;
  logic [7:0] frame[$];

  always @(negedge aclk) begin
    if (udp_data_valid) begin
      mon_q.push_back({udp_data_tlast, udp_data});
`ifdef UDP_RX_CSUM_EN
      if (udp_data_tlast) mon_csum = csum_ok;
`endif
    end
    if (udp_data_tlast && !udp_data_valid) n_orphan++;
    if (drop) n_drop++;
    if (len_err) n_lerr++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                     input logic [15:0] cs);
    frame.delete();
    frame.push_back(src[15:8]); frame.push_back(src[7:0]);
    frame.push_back(dst[15:8]); frame.push_back(dst[7:0]);
    frame.push_back(len[15:8]); frame.push_back(len[7:0]);
    frame.push_back(cs[15:8]);  frame.push_back(cs[7:0]);
  endtask

  task automatic send_frame(input int gap);
    foreach (frame[i]) begin
      @(negedge aclk);
      data_in        = frame[i];
      data_valid     = 1'b1;
      ip_header_done = (i == 0);
    end
    repeat (gap) begin
      @(negedge aclk);
      data_valid     = 1'b0;
      ip_header_done = 1'b0;
      data_in        = '0;
    end
  endtask

  // Compares the beats captured since index q0 against the expected byte list.
  task automatic check_beats(input string name, input int q0, input logic [7:0] exp_b[$]);
    int nb, derr, terr;
    nb = mon_q.size() - q0;
    derr = 0;
    terr = 0;
    check({name, "_beats"}, nb, exp_b.size());
    for (int k = 0; k < nb && k < exp_b.size(); k++) begin
      if (mon_q[q0+k][7:0] != exp_b[k]) derr++;
      if (mon_q[q0+k][8] != (k == exp_b.size() - 1)) terr++;
    end
    check({name, "_data_err"}, derr, 0);
    check({name, "_tlast_err"}, terr, 0);
  endtask

  function automatic logic [15:0] oca(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  typedef struct {
    logic [63:0] tbl;
    logic [3:0]  en;
    int          dst;
    int          len;
    int          np;
    int          beats;
    int          drp;
    int          lerr;
    int          idx;
  } vec_t;

  vec_t vt[11];

  initial begin
    int q0, d0, l0, o0, exp_len;
    logic [7:0] exp_b[$];

    vt[0]  = '{T1, 4'hF, 6000, 12,   4,    4,    0, 0, 1};
    vt[1]  = '{T1, 4'hF, 9000, 12,   4,    0,    1, 0, 1};
    vt[2]  = '{T2, 4'h5, 7000, 10,   2,    2,    0, 0, 0};
    vt[3]  = '{T2, 4'h4, 7000, 10,   2,    2,    0, 0, 2};
    vt[4]  = '{T1, 4'hF, 5000, 6,    4,    0,    0, 1, 0};
    vt[5]  = '{T1, 4'hF, 8000, 1481, 4,    0,    0, 1, 3};
    vt[6]  = '{T1, 4'hF, 6000, 8,    0,    0,    0, 0, 1};
    vt[7]  = '{T1, 4'hF, 5000, 9,    1,    1,    0, 0, 0};
    vt[8]  = '{T1, 4'hF, 8000, 10,   6,    2,    0, 0, 3};
    vt[9]  = '{T1, 4'hF, 7000, 1480, 1472, 1472, 0, 0, 2};
    vt[10] = '{T1, 4'h0, 6000, 12,   4,    0,    1, 0, 2};

    #12;
    check("reset_outputs",
          int'({port_s, udp_length, 6'(port_idx), udp_data, udp_data_valid, udp_data_tlast, drop, len_err} != '0),
          0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    exp_len = 0;
    for (int i = 0; i < 11; i++) begin
      port_table = vt[i].tbl;
      port_en    = vt[i].en;
      q0 = mon_q.size(); d0 = n_drop; l0 = n_lerr; o0 = n_orphan;
      hdr(16'(16'h1100 + i), 16'(vt[i].dst), 16'(vt[i].len), 16'h0000);
      exp_b.delete();
      for (int k = 0; k < vt[i].np; k++) frame.push_back(8'(8'h40 + 16*i + k));
      for (int k = 0; k < vt[i].beats; k++) exp_b.push_back(8'(8'h40 + 16*i + k));
      send_frame(4);
      if (vt[i].drp == 0) exp_len = vt[i].len;
      $display("vector %0d: dst=%0d len=%0d", i, vt[i].dst, vt[i].len);
      check_beats("vec", q0, exp_b);
      check("vec_drop", n_drop - d0, vt[i].drp);
      check("vec_len_err", n_lerr - l0, vt[i].lerr);
      check("vec_orphan_tlast", n_orphan - o0, 0);
      check("vec_port_idx", int'(port_idx), vt[i].idx);
      check("vec_port_s", int'(port_s), 16'h1100 + i);
      check("vec_udp_length", int'(udp_length), exp_len);
    end

    port_table = T1;
    port_en    = 4'hF;
    q0 = mon_q.size();
    hdr(16'hABCD, 16'd6000, 16'd12, 16'h0000);
    frame.push_back(8'hDE); frame.push_back(8'hAD); frame.push_back(8'hBE); frame.push_back(8'hEF);
    send_frame(4);
    exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    check_beats("deadbeef", q0, exp_b);
    check("deadbeef_idx", int'(port_idx), 1);
    check("deadbeef_port_s", int'(port_s), 16'hABCD);

    q0 = mon_q.size(); o0 = n_orphan;
    hdr(16'h0101, 16'd7000, 16'd18, 16'h0000);
    frame.push_back(8'h11); frame.push_back(8'h22);
    send_frame(4);
    check("trunc_beats", mon_q.size() - q0, 2);
    check("trunc_tlast", (mon_q.size() > q0 + 1) ? int'(mon_q[q0+1][8]) : 1, 0);
    check("trunc_orphan", n_orphan - o0, 0);
    q0 = mon_q.size();
    hdr(16'h0202, 16'd7000, 16'd11, 16'h0000);
    frame.push_back(8'h31); frame.push_back(8'h32); frame.push_back(8'h33);
    send_frame(4);
    exp_b = '{8'h31, 8'h32, 8'h33};
    check_beats("after_trunc", q0, exp_b);
    check("after_trunc_idx", int'(port_idx), 2);

    q0 = mon_q.size(); o0 = n_orphan;
    hdr(16'h0303, 16'd6000, 16'd20, 16'h0000);
    for (int k = 0; k < 3; k++) frame.push_back(8'(8'h70 + k));
    foreach (frame[i]) begin
      @(negedge aclk);
      data_in        = frame[i];
      data_valid     = 1'b1;
      ip_header_done = (i == 0);
    end
    @(negedge aclk);
    #1;
    check("pre_reset_valid", int'(udp_data_valid), 1);
    #1 aresetn = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({port_s, udp_length, 6'(port_idx), udp_data, udp_data_valid, udp_data_tlast, drop, len_err} != '0),
          0);
    data_valid = 1'b0;
    ip_header_done = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    check("reset_no_tlast", int'(mon_q[mon_q.size()-1][8]), 0);
    check("reset_orphan", n_orphan - o0, 0);

`ifdef UDP_RX_CSUM_EN
    begin
      logic [15:0] s, cs;
      s = oca(16'h2222, 16'd6000);
      s = oca(s, 16'd11);
      s = oca(s, 16'hDEAD);
      s = oca(s, 16'hBE00);
      s = oca(s, pseudo_sum);
      cs = ~s;
      hdr(16'h2222, 16'd6000, 16'd11, cs);
      frame.push_back(8'hDE); frame.push_back(8'hAD); frame.push_back(8'hBE);
      send_frame(4);
      check("csum_good", int'(mon_csum), 1);
      hdr(16'h2222, 16'd6000, 16'd11, cs);
      frame.push_back(8'hDF); frame.push_back(8'hAD); frame.push_back(8'hBE);
      send_frame(4);
      check("csum_flipped", int'(mon_csum), 0);
      hdr(16'h2222, 16'd6000, 16'd11, 16'h0000);
      frame.push_back(8'hDF); frame.push_back(8'hAD); frame.push_back(8'hBE);
      send_frame(4);
      check("csum_zero_field", int'(mon_csum), 1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
